// File: rtl/db_reg_bank_pkg.sv
// Shared types, bus widths, slave configuration constants and FSM encoding for db_reg_bank.
// The optional byte-enable feature is selected by DB_REG_BANK_BE_EN (see db_reg_bank.sv).
package db_reg_bank_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef logic [ADDR_W-1:0] base_addr_type;
    typedef logic [ADDR_W-1:0] addr_mask_type;

    localparam base_addr_type CFG_BADR_REGBANK = 32'h0000_2000;
    localparam addr_mask_type CFG_MADR_REGBANK = 32'hFFFF_FF80;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } bank_state_e;

    // Width of the word index; a single-register bank still decodes one index bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/db_reg_bank_merge.sv
// Byte-lane merge of a write word into the previous register contents.
// A lane takes wdata when its byte enable is set, otherwise keeps the old byte.
module db_reg_bank_merge
    import db_reg_bank_pkg::*;
(
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] merged_o
);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        merged_o = old_i;
        for (int unsigned k = 0; k < BE_W; k++) begin
            if (be_i[k]) begin
                merged_o[k*8 +: 8] = wdata_i[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/db_reg_bank.sv
// db_reg_bank: NREGS x 32-bit control/status registers behind one DATA_BUS slave port.
// Define DB_REG_BANK_BE_EN to honour dslv_be per byte; otherwise every write replaces the whole word.
module db_reg_bank
    import db_reg_bank_pkg::*;
#(
    parameter base_addr_type     base_addr = CFG_BADR_REGBANK,
    parameter addr_mask_type     addr_mask = CFG_MADR_REGBANK,
    parameter int unsigned       NREGS     = 4,
    parameter logic [NREGS-1:0]  RO_MASK   = '0,
    parameter logic [DATA_W-1:0] reg_init  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [NREGS*DATA_W-1:0] reg_data_o,
    output logic [NREGS-1:0]        reg_wr_o,
    input  logic [NREGS*DATA_W-1:0] status_i,
    input  logic                    dslv_req,
    input  logic                    dslv_we,
    input  logic [ADDR_W-1:0]       dslv_addr,
    input  logic [BE_W-1:0]         dslv_be,
    input  logic [DATA_W-1:0]       dslv_wdata,
    output logic                    dslv_gnt,
    output logic                    dslv_rvalid,
    output logic [DATA_W-1:0]       dslv_rdata,
    output logic                    dslv_err,
    output logic [ADDR_W-1:0]       dslv_conf_base_addr,
    output logic [ADDR_W-1:0]       dslv_conf_addr_mask
);

    localparam int unsigned IDXW     = idx_width(NREGS);
    localparam int unsigned IDX_SPAN = 1 << IDXW;
    // One bit per decodable index, set for indices that map onto a real register.
    localparam logic [IDX_SPAN-1:0] IDX_VALID = {IDX_SPAN{1'b1}} >> (IDX_SPAN - NREGS);

    bank_state_e       state_q, state_d;
    logic [DATA_W-1:0] reg_q [NREGS];
    logic [DATA_W-1:0] reg_d [NREGS];
    logic [NREGS-1:0]  reg_wr_q, reg_wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] view [IDX_SPAN];
    logic [IDXW-1:0]   idx;
    logic              in_range;
    logic              gnt;
    logic [BE_W-1:0]   merge_be;
    logic [DATA_W-1:0] merged;
    logic              unused_inputs;

    assign idx      = dslv_addr[2 +: IDXW];
    assign in_range = IDX_VALID[idx];

    // Read view per index: RO entries show live status, padding indices read as zero.
    for (genvar i = 0; i < IDX_SPAN; i++) begin : g_view
        if (i < NREGS) begin : g_reg
            assign view[i] = RO_MASK[i] ? status_i[i*DATA_W +: DATA_W] : reg_q[i];
            assign reg_data_o[i*DATA_W +: DATA_W] = view[i];
        end else begin : g_pad
            assign view[i] = '0;
        end
    end

`ifdef DB_REG_BANK_BE_EN
    assign merge_be = dslv_be;
`else
    assign merge_be = '1;
`endif

    db_reg_bank_merge u_merge (
        .old_i    (view[idx]),
        .wdata_i  (dslv_wdata),
        .be_i     (merge_be),
        .merged_o (merged)
    );

    always_comb begin
        state_d  = state_q;
        gnt      = 1'b0;
        reg_d    = reg_q;
        reg_wr_d = '0;
        rdata_d  = '0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dslv_req && !rst) begin
                    gnt     = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (dslv_req && !rst) begin
                    gnt = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (gnt) begin
            if (!in_range) begin
                err_d = 1'b1;
            end else if (!dslv_we) begin
                rdata_d = view[idx];
            end else begin
                for (int unsigned i = 0; i < NREGS; i++) begin
                    if (idx == IDXW'(i) && !RO_MASK[i]) begin
                        reg_d[i]    = merged;
                        reg_wr_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            reg_wr_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            // NOTE: this is a small flop array, not a RAM, so every entry is reset to a known value.
            for (int unsigned i = 0; i < NREGS; i++) begin
                reg_q[i] <= reg_init;
            end
        end else begin
            state_q  <= state_d;
            reg_q    <= reg_d;
            reg_wr_q <= reg_wr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign dslv_gnt            = gnt;
    assign dslv_rvalid         = (state_q == ST_ACCESS);
    assign dslv_rdata          = rdata_q;
    assign dslv_err            = err_q;
    assign reg_wr_o            = reg_wr_q;
    assign dslv_conf_base_addr = base_addr;
    assign dslv_conf_addr_mask = addr_mask;

    // Address bits outside the word index, status of RW entries and (by default) be are don't-care.
    assign unused_inputs = ^{dslv_addr, dslv_be, status_i};

endmodule

// File: tb/tb_db_reg_bank.sv
// Self-checking bench for db_reg_bank: directed scenarios, then randomized traffic against a reference model.
// Two instances share the bus stimulus: NREGS=4 with register 3 read-only, and NREGS=3 for out-of-range decode.
module tb_db_reg_bank;
    import db_reg_bank_pkg::*;

    localparam logic [31:0] INIT = 32'hA5A5_0000;
    localparam int NREGS_OF [2] = '{4, 3};
    localparam logic [3:0] RO_OF [2] = '{4'b1000, 4'b0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [3:0]   be = '0;
    logic [127:0] status = '0;
    logic         scramble = 1'b0;

    logic [127:0] rd4;
    logic [3:0]   wr4;
    logic         gnt4, rv4, err4;
    logic [31:0]  rdata4, cb4, cm4;
    logic [95:0]  rd3;
    logic [2:0]   wr3;
    logic         gnt3, rv3, err3;
    logic [31:0]  rdata3, cb3, cm3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: register contents and the response due after the last edge.
    logic [31:0] m_reg [2][4];
    logic        m_rv [2];
    logic [31:0] m_rdata [2];
    logic        m_err [2];
    logic [3:0]  m_wr [2];

    db_reg_bank #(.NREGS(4), .RO_MASK(4'b1000), .reg_init(INIT)) u_dut4 (
        .clk(clk), .rst(rst), .reg_data_o(rd4), .reg_wr_o(wr4), .status_i(status),
        .dslv_req(req), .dslv_we(we), .dslv_addr(addr), .dslv_be(be), .dslv_wdata(wdata),
        .dslv_gnt(gnt4), .dslv_rvalid(rv4), .dslv_rdata(rdata4), .dslv_err(err4),
        .dslv_conf_base_addr(cb4), .dslv_conf_addr_mask(cm4)
    );

    db_reg_bank #(.NREGS(3), .RO_MASK(3'b000), .reg_init(INIT)) u_dut3 (
        .clk(clk), .rst(rst), .reg_data_o(rd3), .reg_wr_o(wr3), .status_i(status[95:0]),
        .dslv_req(req), .dslv_we(we), .dslv_addr(addr), .dslv_be(be), .dslv_wdata(wdata),
        .dslv_gnt(gnt3), .dslv_rvalid(rv3), .dslv_rdata(rdata3), .dslv_err(err3),
        .dslv_conf_base_addr(cb3), .dslv_conf_addr_mask(cm3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] b);
        logic [31:0] m;
`ifdef DB_REG_BANK_BE_EN
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
`else
        m = 32'hFFFF_FFFF;
        b = b;
`endif
        return (old & ~m) | (wd & m);
    endfunction

    function automatic logic [31:0] exp_view(input int k, input int i);
        return RO_OF[k][i] ? status[i*32 +: 32] : m_reg[k][i];
    endfunction

    // Apply one bus edge to the model, using the inputs present at that edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int idx;
            bit inr;
            idx = int'(addr[3:2]);
            inr = idx < NREGS_OF[k];
            if (rst) begin
                for (int i = 0; i < 4; i++) m_reg[k][i] = INIT;
                m_rv[k] = 1'b0; m_rdata[k] = '0; m_err[k] = 1'b0; m_wr[k] = '0;
            end else begin
                m_rv[k] = req; m_rdata[k] = '0; m_err[k] = req && !inr; m_wr[k] = '0;
                if (req && inr) begin
                    if (!we) begin
                        m_rdata[k] = exp_view(k, idx);
                    end else if (!RO_OF[k][idx]) begin
                        m_reg[k][idx] = merge_word(m_reg[k][idx], wdata, be);
                        m_wr[k][idx] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("rvalid4", 32'(rv4), 32'(m_rv[0]));
        check("rdata4", rdata4, m_rdata[0]);
        check("err4", 32'(err4), 32'(m_err[0]));
        check("reg_wr4", 32'(wr4), 32'(m_wr[0]));
        for (int i = 0; i < 4; i++) check($sformatf("reg4[%0d]", i), rd4[i*32 +: 32], exp_view(0, i));
        check("rvalid3", 32'(rv3), 32'(m_rv[1]));
        check("rdata3", rdata3, m_rdata[1]);
        check("err3", 32'(err3), 32'(m_err[1]));
        check("reg_wr3", 32'(wr3), 32'(m_wr[1][2:0]));
        for (int i = 0; i < 3; i++) check($sformatf("reg3[%0d]", i), rd3[i*32 +: 32], exp_view(1, i));
    endtask

    // One bus cycle: drive, check combinational gnt, clock, optionally disturb status, check responses.
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b);
        req = r; we = w; addr = a; wdata = wd; be = b;
        #1;
        check("gnt4", 32'(gnt4), 32'(r && !rst));
        check("gnt3", 32'(gnt3), 32'(r && !rst));
        @(posedge clk);
        model_edge();
        #1;
        if (scramble) status = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        status[127:96] = 32'hDEAD_BEEF;

        // Reset state
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("rst_reg0", rd4[31:0], 32'hA5A5_0000);
        check("rst_reg2", rd4[95:64], 32'hA5A5_0000);
        check("rst_rvalid", 32'(rv4), 32'h0);
        check("rst_reg_wr", 32'(wr4), 32'h0);
        check("conf_base", cb4, CFG_BADR_REGBANK);
        check("conf_mask", cm4, CFG_MADR_REGBANK);
        rst = 1'b0;

        // Write then read-back of the same register on the next cycle
        step(1'b1, 1'b1, 32'h0000_2008, 32'h1234_5678, 4'hF);
        check("wr_pulse", 32'(wr4), 32'h4);
        check("wr_resp", 32'(rv4), 32'h1);
        step(1'b1, 1'b0, 32'h0000_2008, 32'h0, 4'h0);
        check("rd_back", rdata4, 32'h1234_5678);
        check("rd_resp", 32'(rv4), 32'h1);
        check("rd_no_pulse", 32'(wr4), 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("idle_rvalid", 32'(rv4), 32'h0);

        // Partial write
        step(1'b1, 1'b1, 32'h0000_2004, 32'hFFFF_FFFF, 4'hF);
        step(1'b1, 1'b1, 32'h0000_2004, 32'h0000_00AB, 4'b0001);
`ifdef DB_REG_BANK_BE_EN
        check("be_merge", rd4[63:32], 32'hFFFF_FFAB);
`else
        check("be_ignored", rd4[63:32], 32'h0000_00AB);
`endif

        // Read-only register and out-of-range index (offset 0xC)
        step(1'b1, 1'b1, 32'h0000_200C, 32'h0, 4'hF);
        check("ro_wr_pulse", 32'(wr4), 32'h0);
        check("ro_wr_err", 32'(err4), 32'h0);
        check("oor_wr_err", 32'(err3), 32'h1);
        check("oor_wr_pulse", 32'(wr3), 32'h0);
        step(1'b1, 1'b0, 32'h0000_200C, 32'h0, 4'h0);
        check("ro_rdata", rdata4, 32'hDEAD_BEEF);
        check("ro_rd_err", 32'(err4), 32'h0);
        check("oor_rd_err", 32'(err3), 32'h1);
        check("oor_rdata", rdata3, 32'h0);
        check("oor_keep", rd3[95:64], 32'h1234_5678);

        // Reset during a read burst
        step(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
        step(1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'h0);
        rst = 1'b1;
        step(1'b1, 1'b0, 32'h0000_2008, 32'h0, 4'h0);
        check("rst_mid_rvalid", 32'(rv4), 32'h0);
        check("rst_mid_reg2", rd4[95:64], 32'hA5A5_0000);
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Randomized traffic, including occasional resets and status changes after the grant edge
        scramble = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 3) != 0, 1'($urandom()), $urandom(), $urandom(), 4'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
